alb_issue: RTL and testbench

ALB_ISSUE -- requirements
Module: alb_issue

---
 rtl/alb_pkg.sv | 36 +++
 rtl/alb_regfile.sv | 41 ++++
 rtl/alb_issue.sv | 196 +++++++++++++++++++
 tb/tb_alb_issue.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alb_pkg.sv
// alb_pkg: shared types and constants for the ALB issue stage and its register file.
package alb_pkg;

    localparam int unsigned RegW  = 8;
    localparam int unsigned RegN  = 8;
    localparam int unsigned RegAw = 3;

    // Opcode encoding as driven on alb_mi
    typedef enum logic [1:0] {
        OpSub = 2'b00,
        OpAnd = 2'b01,
        OpAdd = 2'b10,
        OpOr  = 2'b11
    } alb_op_e;

    typedef enum logic [1:0] {
        CinZero   = 2'b00,
        CinOne    = 2'b01,
        CinStored = 2'b10,
        CinRsvd   = 2'b11
    } cin_sel_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWait  = 2'b10,
        StWb    = 2'b11
    } state_e;

    // Bit positions inside the {C,Z,N,V} flags vector
    localparam int unsigned FlagC = 3;
    localparam int unsigned FlagZ = 2;
    localparam int unsigned FlagN = 1;
    localparam int unsigned FlagV = 0;

endpackage

// File: rtl/alb_regfile.sv
// alb_regfile: 8x8 register file, two async read ports, one sync write port, r0 reads zero.
// Optional macro ALB_ISSUE_DBG_EN adds a third combinational debug read port.
module alb_regfile
    import alb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [RegAw-1:0] raddr_a,
    output logic [RegW-1:0]  rdata_a,
    input  logic [RegAw-1:0] raddr_b,
    output logic [RegW-1:0]  rdata_b,
`ifdef ALB_ISSUE_DBG_EN
    input  logic [RegAw-1:0] dbg_addr,
    output logic [RegW-1:0]  dbg_data,
`endif
    input  logic            we,
    input  logic [RegAw-1:0] waddr,
    input  logic [RegW-1:0]  wdata
);

    logic [RegW-1:0] mem_q [RegN];

    // Storage: cleared on reset, writes to r0 dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(RegN); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];

`ifdef ALB_ISSUE_DBG_EN
    assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
`endif

endmodule

// File: rtl/alb_issue.sv
// alb_issue: single-instruction issue stage driving an external fixed-latency ALB.
// LDI writes the register file directly; ALB ops go IDLE -> ISSUE -> WAIT -> WB.
// Optional macro ALB_ISSUE_DBG_EN adds dbg_addr/dbg_data register-file read port.
module alb_issue
    import alb_pkg::*;
#(
    parameter int unsigned ALB_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [1:0] instr_op,
    input  logic       instr_ld,
    input  logic [7:0] instr_imm,
    input  logic [2:0] instr_ra,
    input  logic [2:0] instr_rb,
    input  logic [2:0] instr_rd,
    input  logic [1:0] instr_cin_sel,
    output logic [7:0] alb_r,
    output logic [7:0] alb_s,
    output logic       alb_ci,
    output logic [1:0] alb_mi,
    input  logic [7:0] alb_f,
    input  logic       alb_co,
    input  logic       alb_zo,
    input  logic       alb_no,
    input  logic       alb_vo,
`ifdef ALB_ISSUE_DBG_EN
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data,
`endif
    output logic       wb_valid,
    output logic [2:0] wb_rd,
    output logic [7:0] wb_data,
    output logic [3:0] flags
);

    localparam logic [2:0] LatCnt = 3'(ALB_LAT);

    state_e     state_q, state_d;
    logic       accept;
    logic       ci_sel;

    alb_op_e    op_q;
    logic [2:0] ra_q, rb_q, rd_q;
    logic       ci_q;
    logic [2:0] cnt_q;

    logic [7:0] alb_r_q, alb_s_q;
    logic       alb_ci_q;
    logic [1:0] alb_mi_q;

    logic       wb_valid_q;
    logic [2:0] wb_rd_q;
    logic [7:0] wb_data_q;
    logic [3:0] flags_q;

    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [7:0] rf_rdata_a, rf_rdata_b;

    alb_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (ra_q),
        .rdata_a (rf_rdata_a),
        .raddr_b (rb_q),
        .rdata_b (rf_rdata_b),
`ifdef ALB_ISSUE_DBG_EN
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
`endif
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    assign accept = instr_valid & instr_ready;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept && !instr_ld) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (cnt_q == LatCnt) state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: handshake and register-file write port steering
    always_comb begin
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = instr_rd;
        rf_wdata    = instr_imm;
        case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                rf_we       = instr_valid & instr_ld;
            end
            StWb: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = alb_f;
            end
            default: ;
        endcase
    end

    // Carry-in chosen at accept time so a stored carry reflects flags then
    always_comb begin
        ci_sel = 1'b0;
        case (cin_sel_e'(instr_cin_sel))
            CinOne:    ci_sel = 1'b1;
            CinStored: ci_sel = flags_q[FlagC];
            default:   ci_sel = 1'b0;
        endcase
    end

    // Datapath: instruction latch, operand registers, latency counter, writeback and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= OpSub;
            ra_q       <= '0;
            rb_q       <= '0;
            rd_q       <= '0;
            ci_q       <= 1'b0;
            cnt_q      <= '0;
            alb_r_q    <= '0;
            alb_s_q    <= '0;
            alb_ci_q   <= 1'b0;
            alb_mi_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            flags_q    <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            if (accept && instr_ld) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= instr_rd;
                wb_data_q  <= instr_imm;
            end
            if (accept && !instr_ld) begin
                op_q <= alb_op_e'(instr_op);
                ra_q <= instr_ra;
                rb_q <= instr_rb;
                rd_q <= instr_rd;
                ci_q <= ci_sel;
            end
            if (state_q == StIssue) begin
                // Operands stay registered until the next ALB issue
                alb_r_q  <= rf_rdata_a;
                alb_s_q  <= rf_rdata_b;
                alb_ci_q <= ci_q;
                alb_mi_q <= op_q;
                cnt_q    <= 3'd1;
            end
            if (state_q == StWait) begin
                cnt_q <= cnt_q + 3'd1;
            end
            if (state_q == StWb) begin
                wb_valid_q     <= 1'b1;
                wb_rd_q        <= rd_q;
                wb_data_q      <= alb_f;
                flags_q[FlagC] <= alb_co;
                flags_q[FlagZ] <= alb_zo;
                flags_q[FlagN] <= alb_no;
                flags_q[FlagV] <= alb_vo;
            end
        end
    end

    assign alb_r    = alb_r_q;
    assign alb_s    = alb_s_q;
    assign alb_ci   = alb_ci_q;
    assign alb_mi   = alb_mi_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign flags    = flags_q;

endmodule

// File: tb/tb_alb_issue.sv
// tb_alb_issue: directed table-driven bench for alb_issue with a fixed-latency ALB model.
module tb_alb_issue;

    localparam int unsigned LAT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] instr_op;
    logic       instr_ld;
    logic [7:0] instr_imm;
    logic [2:0] instr_ra, instr_rb, instr_rd;
    logic [1:0] instr_cin_sel;
    logic [7:0] alb_r, alb_s;
    logic       alb_ci;
    logic [1:0] alb_mi;
    logic [7:0] alb_f;
    logic       alb_co, alb_zo, alb_no, alb_vo;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic [3:0] flags;
`ifdef ALB_ISSUE_DBG_EN
    logic [2:0] dbg_addr = 3'd0;
    logic [7:0] dbg_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alb_issue #(.ALB_LAT(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_ld     (instr_ld),
        .instr_imm    (instr_imm),
        .instr_ra     (instr_ra),
        .instr_rb     (instr_rb),
        .instr_rd     (instr_rd),
        .instr_cin_sel(instr_cin_sel),
        .alb_r        (alb_r),
        .alb_s        (alb_s),
        .alb_ci       (alb_ci),
        .alb_mi       (alb_mi),
        .alb_f        (alb_f),
        .alb_co       (alb_co),
        .alb_zo       (alb_zo),
        .alb_no       (alb_no),
        .alb_vo       (alb_vo),
`ifdef ALB_ISSUE_DBG_EN
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
`endif
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flags        (flags)
    );

    // ALB model: result appears LAT cycles after the operands change
    logic [8:0]  m_sum;
    logic [7:0]  m_sop, m_f;
    logic        m_c, m_v;
    logic [11:0] m_now;
    logic [11:0] pipe [LAT];

    always_comb begin
        m_sop = (alb_mi == 2'b00) ? ~alb_s : alb_s;
        m_sum = {1'b0, alb_r} + {1'b0, m_sop} + {8'd0, alb_ci};
        m_f   = 8'd0;
        m_c   = 1'b0;
        m_v   = 1'b0;
        case (alb_mi)
            2'b00, 2'b10: begin
                m_f = m_sum[7:0];
                m_c = m_sum[8];
                m_v = (alb_r[7] == m_sop[7]) && (m_sum[7] != alb_r[7]);
            end
            2'b01:   m_f = alb_r & alb_s;
            default: m_f = alb_r | alb_s;
        endcase
        m_now = {m_f, m_c, (m_f == 8'd0), m_f[7], m_v};
    end

    always @(posedge clk) begin
        pipe[0] <= m_now;
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end

    assign {alb_f, alb_co, alb_zo, alb_no, alb_vo} = pipe[LAT-1];

    typedef struct {
        logic       ld;
        logic [1:0] op;
        logic [2:0] ra, rb, rd;
        logic [7:0] imm;
        logic [1:0] cin;
        logic [7:0] exp_r, exp_s;
        logic       exp_ci;
        logic [7:0] exp_data;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic ld, input logic [1:0] op, input logic [2:0] ra,
                                input logic [2:0] rb, input logic [2:0] rd,
                                input logic [7:0] imm, input logic [1:0] cin,
                                input logic [7:0] er, input logic [7:0] es, input logic eci,
                                input logic [7:0] ed, input logic [3:0] ef);
        vec_t v;
        v.ld = ld; v.op = op; v.ra = ra; v.rb = rb; v.rd = rd; v.imm = imm; v.cin = cin;
        v.exp_r = er; v.exp_s = es; v.exp_ci = eci; v.exp_data = ed; v.exp_flags = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Starts just after a rising edge; leaves just after the writeback edge
    task automatic run_vec(input int idx, input vec_t v);
        int n;
        n = 0;
        while (!instr_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("v%0d_ready", idx), 32'(instr_ready), 32'd1);
        instr_valid   = 1'b1;
        instr_ld      = v.ld;
        instr_op      = v.op;
        instr_ra      = v.ra;
        instr_rb      = v.rb;
        instr_rd      = v.rd;
        instr_imm     = v.imm;
        instr_cin_sel = v.cin;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        if (!v.ld) begin
            @(posedge clk); #1;
            chk($sformatf("v%0d_busy", idx), 32'(instr_ready), 32'd0);
            chk($sformatf("v%0d_alb_r", idx), 32'(alb_r), 32'(v.exp_r));
            chk($sformatf("v%0d_alb_s", idx), 32'(alb_s), 32'(v.exp_s));
            chk($sformatf("v%0d_alb_ci", idx), 32'(alb_ci), 32'(v.exp_ci));
            chk($sformatf("v%0d_alb_mi", idx), 32'(alb_mi), 32'(v.op));
            n = 1;
            while (!wb_valid && n < 30) begin
                @(posedge clk); #1;
                n++;
            end
            chk($sformatf("v%0d_latency", idx), 32'(n), 32'(LAT + 2));
        end
        chk($sformatf("v%0d_wb_valid", idx), 32'(wb_valid), 32'd1);
        chk($sformatf("v%0d_wb_rd", idx), 32'(wb_rd), 32'(v.rd));
        chk($sformatf("v%0d_wb_data", idx), 32'(wb_data), 32'(v.exp_data));
        chk($sformatf("v%0d_flags", idx), 32'(flags), 32'(v.exp_flags));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        int busy;
        int pulses;

        //            ld    op     ra    rb    rd    imm    cin    r      s      ci    data   flags
        vecs[0]  = mk(1'b1, 2'd0, 3'd0, 3'd0, 3'd1, 8'h05, 2'd0, 8'h00, 8'h00, 1'b0, 8'h05, 4'h0);
        vecs[1]  = mk(1'b1, 2'd0, 3'd0, 3'd0, 3'd2, 8'h03, 2'd0, 8'h00, 8'h00, 1'b0, 8'h03, 4'h0);
        vecs[2]  = mk(1'b0, 2'd0, 3'd1, 3'd2, 3'd3, 8'h00, 2'd1, 8'h05, 8'h03, 1'b1, 8'h02, 4'h8);
        vecs[3]  = mk(1'b1, 2'd0, 3'd0, 3'd0, 3'd1, 8'hFF, 2'd0, 8'h00, 8'h00, 1'b0, 8'hFF, 4'h8);
        vecs[4]  = mk(1'b1, 2'd0, 3'd0, 3'd0, 3'd2, 8'h01, 2'd0, 8'h00, 8'h00, 1'b0, 8'h01, 4'h8);
        vecs[5]  = mk(1'b0, 2'd2, 3'd1, 3'd2, 3'd4, 8'h00, 2'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'hC);
        vecs[6]  = mk(1'b0, 2'd2, 3'd0, 3'd0, 3'd5, 8'h00, 2'd2, 8'h00, 8'h00, 1'b1, 8'h01, 4'h0);
        vecs[7]  = mk(1'b1, 2'd0, 3'd0, 3'd0, 3'd0, 8'hAA, 2'd0, 8'h00, 8'h00, 1'b0, 8'hAA, 4'h0);
        vecs[8]  = mk(1'b0, 2'd3, 3'd0, 3'd0, 3'd6, 8'h00, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 4'h4);
        vecs[9]  = mk(1'b0, 2'd0, 3'd2, 3'd3, 3'd7, 8'h00, 2'd3, 8'h01, 8'h02, 1'b0, 8'hFE, 4'h2);
        vecs[10] = mk(1'b0, 2'd1, 3'd7, 3'd3, 3'd1, 8'h00, 2'd0, 8'hFE, 8'h02, 1'b0, 8'h02, 4'h0);
        vecs[11] = mk(1'b1, 2'd0, 3'd0, 3'd0, 3'd2, 8'h7F, 2'd0, 8'h00, 8'h00, 1'b0, 8'h7F, 4'h0);
        vecs[12] = mk(1'b0, 2'd2, 3'd2, 3'd2, 3'd2, 8'h00, 2'd0, 8'h7F, 8'h7F, 1'b0, 8'hFE, 4'h3);
        vecs[13] = mk(1'b0, 2'd3, 3'd2, 3'd0, 3'd4, 8'h00, 2'd2, 8'hFE, 8'h00, 1'b0, 8'hFE, 4'h2);
        vecs[14] = mk(1'b0, 2'd0, 3'd4, 3'd4, 3'd5, 8'h00, 2'd1, 8'hFE, 8'hFE, 1'b1, 8'h00, 4'hC);
        vecs[15] = mk(1'b0, 2'd2, 3'd5, 3'd1, 3'd6, 8'h00, 2'd2, 8'h00, 8'h02, 1'b1, 8'h03, 4'h0);

        reset         = 1'b1;
        instr_valid   = 1'b0;
        instr_ld      = 1'b0;
        instr_op      = 2'd0;
        instr_ra      = 3'd0;
        instr_rb      = 3'd0;
        instr_rd      = 3'd0;
        instr_imm     = 8'd0;
        instr_cin_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd_data", {21'd0, wb_rd, wb_data}, 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_alb", {21'd0, alb_r, alb_s, alb_ci, alb_mi}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(instr_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            run_vec(i, vecs[i]);
        end
        @(posedge clk); #1;
        chk("wb_single_pulse", 32'(wb_valid), 32'd0);

        // Valid held through a busy ALB op; a follow-on LDI is taken exactly once
        instr_valid   = 1'b1;
        instr_ld      = 1'b0;
        instr_op      = 2'd2;
        instr_ra      = 3'd1;
        instr_rb      = 3'd2;
        instr_rd      = 3'd5;
        instr_cin_sel = 2'd0;
        @(posedge clk); #1;
        instr_ld  = 1'b1;
        instr_rd  = 3'd6;
        instr_imm = 8'h5A;
        busy = 0;
        n = 0;
        while (!instr_ready && n < 20) begin
            busy++;
            @(posedge clk); #1;
            n++;
        end
        chk("hold_busy_cycles", 32'(busy), 32'(LAT + 2));
        chk("hold_alb_wb", {23'd0, wb_valid, wb_rd, wb_data}, {23'd0, 1'b1, 3'd5, 8'h00});
        chk("hold_alb_flags", 32'(flags), 32'hC);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("hold_ldi_wb", {23'd0, wb_valid, wb_rd, wb_data}, {23'd0, 1'b1, 3'd6, 8'h5A});
        chk("hold_ldi_flags", 32'(flags), 32'hC);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wb_valid) pulses++;
        end
        chk("hold_no_repeat", 32'(pulses), 32'd0);
        chk("hold_ready_after", 32'(instr_ready), 32'd1);

        // Reset while an ADD r7 sits in WAIT
        instr_valid   = 1'b1;
        instr_ld      = 1'b0;
        instr_op      = 2'd2;
        instr_ra      = 3'd1;
        instr_rb      = 3'd1;
        instr_rd      = 3'd7;
        instr_cin_sel = 2'd0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_operand", 32'(alb_r), 32'h02);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_rst_ready", 32'(instr_ready), 32'd1);
        chk("abort_rst_alb", {21'd0, alb_r, alb_s, alb_ci, alb_mi}, 32'd0);
        chk("abort_rst_flags", 32'(flags), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (wb_valid) pulses++;
        end
        chk("abort_no_wb", 32'(pulses), 32'd0);
        chk("abort_ready", 32'(instr_ready), 32'd1);
        run_vec(100, mk(1'b0, 2'd3, 3'd7, 3'd0, 3'd6, 8'h00, 2'd0,
                        8'h00, 8'h00, 1'b0, 8'h00, 4'h4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
